// File: rtl/mem_access_unit.sv
// Data-memory access unit for the MEM stage.
// Runs an IDLE -> BUSY -> DONE handshake against a ready-based memory,
// formats load data into ReadData, aligns store data and byte enables,
// flags misaligned accesses and bounds the wait for mem_ready with a timeout.
module mem_access_unit #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DM_ADDR_W = 9,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [2:0]           Funct3,
  input  logic [DATA_W-1:0]    ALUResult_EXMEM,
  input  logic [DATA_W-1:0]    WriteData,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DM_ADDR_W-1:0] mem_addr,
  output logic [3:0]           mem_be,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 mem_ready,
  output logic [DATA_W-1:0]    ReadData,
  output logic                 Stall,
  output logic                 misalign,
  output logic                 mem_err
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

  // Request attributes captured on acceptance so the bus stays stable in BUSY
  logic [DM_ADDR_W-1:0]   addr_q;
  logic [3:0]             be_q;
  logic [DATA_W-1:0]      wdata_q;
  logic                   store_q;
  logic [2:0]             f3_q;
  logic [1:0]             off_q;
  logic                   capture;

  logic                   access_req;
  logic                   is_store;
  size_e                  size_c;
  logic [1:0]             off_c;
  logic                   misaligned_c;
  logic [DM_ADDR_W-1:0]   addr_c;
  logic [3:0]             be_c;
  logic [DATA_W-1:0]      wdata_c;
  logic [7:0]             byte_sel;
  logic [15:0]            half_sel;
  logic [DATA_W-1:0]      load_fmt;

  // Address bits above the word address and below it are not part of mem_addr
  logic                   unused_addr_bits;
  assign unused_addr_bits = ^ALUResult_EXMEM[DATA_W-1:DM_ADDR_W+2];

  assign access_req = valid & (MemRead | MemWrite);
  // MemRead wins when both controls are high
  assign is_store   = MemWrite & ~MemRead;
  assign off_c      = ALUResult_EXMEM[1:0];
  assign addr_c     = ALUResult_EXMEM[DM_ADDR_W+1:2];

  // Access size from Funct3; unused encodings behave as a word access
  always_comb begin
    case (Funct3)
      3'b000, 3'b100: size_c = SZ_B;
      3'b001, 3'b101: size_c = SZ_H;
      default:        size_c = SZ_W;
    endcase
  end

  // Alignment check, byte enables and lane-replicated store data
  always_comb begin
    misaligned_c = 1'b0;
    be_c         = 4'b1111;
    wdata_c      = '0;
    case (size_c)
      SZ_H:    misaligned_c = off_c[0];
      SZ_W:    misaligned_c = (off_c != 2'b00);
      default: misaligned_c = 1'b0;
    endcase
    if (is_store) begin
      case (size_c)
        SZ_B: begin
          be_c    = 4'b0001 << off_c;
          wdata_c = {4{WriteData[7:0]}};
        end
        SZ_H: begin
          be_c    = 4'b0011 << off_c;
          wdata_c = {2{WriteData[15:0]}};
        end
        default: begin
          be_c    = 4'b1111;
          wdata_c = WriteData;
        end
      endcase
    end
  end

  // Load formatting: lane select by the captured offset, then extend
  always_comb begin
    byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_fmt = {24'h000000, byte_sel};
      3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_fmt = {16'h0000, half_sel};
      default: load_fmt = mem_rdata;
    endcase
  end

  // Next-state and output logic; every output is forced low while reset is held
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    capture   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    Stall     = 1'b0;
    misalign  = 1'b0;
    mem_err   = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (access_req) begin
            if (misaligned_c) begin
              misalign = 1'b1;
            end else begin
              Stall     = 1'b1;
              capture   = 1'b1;
              cnt_d     = '0;
              state_d   = S_BUSY;
              mem_addr  = addr_c;
              mem_be    = be_c;
              mem_wdata = wdata_c;
            end
          end
        end
        S_BUSY: begin
          mem_req   = 1'b1;
          Stall     = 1'b1;
          mem_we    = store_q;
          mem_addr  = addr_q;
          mem_be    = be_q;
          mem_wdata = wdata_q;
          if (mem_ready) begin
            state_d = S_DONE;
            if (!store_q) rdata_d = load_fmt;
          end else if (cnt_q == CNT_W'(TIMEOUT)) begin
            mem_err = 1'b1;
            state_d = S_DONE;
            // A timed-out store leaves ReadData alone, like any other store
            if (!store_q) rdata_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, wait counter and load result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Request capture on acceptance in IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      f3_q    <= '0;
      off_q   <= '0;
    end else if (capture) begin
      addr_q  <= addr_c;
      be_q    <= be_c;
      wdata_q <= wdata_c;
      store_q <= is_store;
      f3_q    <= Funct3;
      off_q   <= off_c;
    end
  end

  assign ReadData = rdata_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, data width; DM_ADDR_W, default 9, data-memory word-address width; TIMEOUT, default 15, maximum wait cycles for mem_ready.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 valid  input  1  the EX/MEM instruction is valid.
REQ-005 MemRead, MemWrite  input  1 each  load and store controls from EX/MEM.
REQ-006 Funct3  input  3  access size and sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-007 ALUResult_EXMEM  input  DATA_W  byte address.
REQ-008 WriteData  input  DATA_W  store data (rs2).
REQ-009 mem_req, mem_we  output  1 each  memory request and write enable.
REQ-010 mem_addr  output  DM_ADDR_W  word address, equal to ALUResult_EXMEM[DM_ADDR_W+1:2].
REQ-011 mem_be  output  4  byte enables; mem_wdata  output  DATA_W  lane-aligned store data.
REQ-012 mem_rdata  input  DATA_W; mem_ready  input  1  read data valid / write accepted.
REQ-013 ReadData  output  DATA_W  registered, formatted load result consumed by MEM/WB.
REQ-014 Stall  output  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-015 misalign, mem_err  output  1 each  single-cycle fault pulses.

Function
REQ-016 An access SHALL be requested when valid=1 and (MemRead|MemWrite)=1; MemRead SHALL take priority, so MemWrite is ignored when both are high.
REQ-017 FSM states SHALL be IDLE, BUSY, DONE; the reset state is IDLE.
REQ-018 IDLE: on an aligned access request, Stall SHALL be 1 combinationally, the next state SHALL be BUSY, and the wait counter SHALL clear to 0.
REQ-019 BUSY: mem_req SHALL be 1 and Stall SHALL be 1; addr, be, wdata and we SHALL be held stable.
  - mem_ready=1 -> DONE; for a load, ReadData SHALL capture the formatted mem_rdata.
  - Otherwise the counter SHALL increment; when counter=TIMEOUT, mem_err SHALL pulse, ReadData SHALL be 0, and the next state SHALL be DONE.
REQ-020 DONE: Stall SHALL be 0 and mem_req SHALL be 0; all request inputs SHALL be ignored; the next state SHALL be IDLE unconditionally, so the same instruction is never reissued.
REQ-021 Minimum access latency SHALL be 3 cycles (IDLE, BUSY, DONE) with zero-wait memory; each extra mem_ready wait cycle SHALL add one cycle.
REQ-022 Misalignment is defined as halfword with addr[0]=1, or word with addr[1:0]!=0.
  - A misaligned access SHALL pulse misalign for one cycle in IDLE.
  - It SHALL issue no mem_req, leave Stall at 0, and leave ReadData unchanged.
  - The state SHALL remain IDLE.
REQ-023 Load formatting SHALL select the byte or halfword lane by addr[1:0].
  - LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL pass the word through.
  - An unused Funct3 SHALL be treated as LW.
REQ-024 Store byte enables SHALL be:
  - SB: 0001<<addr[1:0].
  - SH: 0011<<addr[1:0].
  - SW: 1111.
REQ-025 Store data SHALL be WriteData's low byte or halfword replicated across all lanes.
REQ-026 mem_we SHALL equal 1 only in BUSY for a store.
REQ-027 A store SHALL NOT modify ReadData.
REQ-028 When valid=0 or there is no access, all memory outputs SHALL be 0, Stall SHALL be 0, and ReadData SHALL hold its value.
REQ-029 mem_ready while in IDLE or DONE SHALL be ignored.

Reset
REQ-030 Asserting reset at any time, including mid-BUSY, SHALL immediately force: state IDLE, counter 0, ReadData 0, and mem_req, mem_we, Stall, misalign and mem_err all 0.
REQ-031 After reset release, the first rising edge SHALL evaluate the inputs from IDLE.

Verification
REQ-032 LW at addr 0x10 with mem_rdata=0xDEADBEEF and mem_ready on the first BUSY cycle -> mem_addr=4, Stall high for 2 cycles, ReadData=0xDEADBEEF in DONE.
REQ-033 LB at addr 0x13 with mem_rdata=0x80123456 -> ReadData=0xFFFFFF80; the same access as LBU -> 0x00000080; LH at 0x12 -> 0xFFFF8012.
REQ-034 SB at addr 0x05 with WriteData=0x000000AB -> mem_be=0010, mem_wdata=0xABABABAB, mem_we=1 in BUSY, ReadData unchanged.
REQ-035 LW at addr 0x06 -> misalign pulses for 1 cycle, no mem_req, Stall stays 0; SH at 0x03 gives the same result.
REQ-036 mem_ready held low -> mem_err pulses after 15 BUSY wait cycles, ReadData=0, DONE, then IDLE.
REQ-037 Reset asserted in the 2nd BUSY cycle -> mem_req and Stall drop to 0 asynchronously, state IDLE, the access is not reissued after release until a new request.
